edge_monitor: RTL and testbench

EDGE_MONITOR -- requirements
Module: edge_monitor

---
 rtl/edge_monitor_pkg.sv | 34 +++
 rtl/edge_monitor_chan.sv | 109 ++++++++++
 rtl/edge_monitor.sv | 68 ++++++
 tb/tb_edge_monitor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/edge_monitor_pkg.sv
// edge_monitor_pkg
//   Shared definitions for the edge monitor:
//   - mode_e: 2-bit per-channel edge qualifier (none / rise / fall / both)
//   - legal parameter bounds checked at elaboration by the top
//   - edge_qualified(): maps a mode and the registered edge pulses to an event
package edge_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int N_CH_MIN     = 1;
  localparam int N_CH_MAX     = 32;
  localparam int FILT_CYC_MIN = 1;
  localparam int CNT_W_MIN    = 1;

  // Event qualification: rise counts in RISE/BOTH, fall counts in FALL/BOTH.
  function automatic logic edge_qualified(mode_e m, logic rise, logic fall);
    logic q;
    q = 1'b0;
    case (m)
      MODE_NONE: q = 1'b0;
      MODE_RISE: q = rise;
      MODE_FALL: q = fall;
      MODE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_monitor_chan.sv
// edge_monitor_chan
//   One channel of the edge monitor: debounce filter, registered edge
//   pulses, mode-qualified event, sticky flag and saturating event counter.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   a_i               raw serial input
//   mode_i[1:0]       edge qualifier (mode_e encoding)
//   clr_i             clear pulse for sticky flag and counter
//   filt_o            debounced level
//   rising_edge_o     one-cycle pulse on filtered 0->1
//   falling_edge_o    one-cycle pulse on filtered 1->0
//   event_o           combinational mode-qualified edge
//   sticky_o          latched qualified edge, held until cleared
//   count_o[CNT_W-1:0] saturating count of qualified edges
//   stab_o            stability counter, exposed for observation
module edge_monitor_chan
  import edge_monitor_pkg::*;
#(
  parameter int FILT_CYC = 3,
  parameter int CNT_W    = 8,
  localparam int SW      = (FILT_CYC == 1) ? 1 : $clog2(FILT_CYC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             filt_o,
  output logic             rising_edge_o,
  output logic             falling_edge_o,
  output logic             event_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] count_o,
  output logic [SW-1:0]    stab_o
);

  localparam logic [SW-1:0]    STAB_LAST = SW'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SW-1:0]    stab_q, stab_d;
  logic             filt_q, filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             event_w;

  // Debounce: a differing input must be seen on FILT_CYC consecutive edges.
  // Any sample matching the filtered level restarts the count, so glitches
  // shorter than FILT_CYC never reach the output.
  always_comb begin
    filt_d = filt_q;
    stab_d = stab_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (a_i == filt_q) begin
      stab_d = '0;
    end else if (stab_q == STAB_LAST) begin
      filt_d = a_i;
      stab_d = '0;
      rise_d = a_i;
      fall_d = ~a_i;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  // Mode is applied after the pulse registers so a mode change is seen
  // in the same cycle without disturbing the filter.
  assign event_w = edge_qualified(mode_e'(mode_i), rise_q, fall_q);

  // Set wins over clear; a clear coincident with an event counts that event.
  always_comb begin
    sticky_d = sticky_q;
    if (event_w)    sticky_d = 1'b1;
    else if (clr_i) sticky_d = 1'b0;

    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = CNT_W'(event_w);
    else if (event_w && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stab_q   <= '0;
      filt_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stab_q   <= stab_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign filt_o         = filt_q;
  assign rising_edge_o  = rise_q;
  assign falling_edge_o = fall_q;
  assign event_o        = event_w;
  assign sticky_o       = sticky_q;
  assign count_o        = cnt_q;
  assign stab_o         = stab_q;

endmodule

// File: rtl/edge_monitor.sv
// edge_monitor
//   N_CH independent debounced edge monitors with per-channel mode,
//   sticky flag, saturating counter and a shared interrupt.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   a_i[N_CH-1:0]              raw inputs
//   mode_i[2*N_CH-1:0]         per-channel mode, channel i at [2i+1:2i]
//   clr_i[N_CH-1:0]            per-channel clear for sticky and counter
//   filt_o[N_CH-1:0]           debounced levels
//   rising_edge_o/falling_edge_o[N_CH-1:0]  filtered edge pulses
//   event_o[N_CH-1:0]          mode-qualified edge pulses
//   sticky_o[N_CH-1:0]         latched qualified edges
//   count_o[N_CH*CNT_W-1:0]    counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]
//   irq_o                      OR of sticky_o
module edge_monitor
  import edge_monitor_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int FILT_CYC = 3,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       a_i,
  input  logic [2*N_CH-1:0]     mode_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       filt_o,
  output logic [N_CH-1:0]       rising_edge_o,
  output logic [N_CH-1:0]       falling_edge_o,
  output logic [N_CH-1:0]       event_o,
  output logic [N_CH-1:0]       sticky_o,
  output logic [N_CH*CNT_W-1:0] count_o,
  output logic                  irq_o
);

  localparam int SW = (FILT_CYC == 1) ? 1 : $clog2(FILT_CYC + 1);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
      FILT_CYC < FILT_CYC_MIN || CNT_W < CNT_W_MIN) begin : g_param_err
    $error("edge_monitor: parameter out of legal range");
  end

  // Per-channel stability counters, kept for observation by checkers.
  logic [SW-1:0] stab_dbg [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_monitor_chan #(
      .FILT_CYC (FILT_CYC),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .a_i            (a_i[i]),
      .mode_i         (mode_i[2*i +: 2]),
      .clr_i          (clr_i[i]),
      .filt_o         (filt_o[i]),
      .rising_edge_o  (rising_edge_o[i]),
      .falling_edge_o (falling_edge_o[i]),
      .event_o        (event_o[i]),
      .sticky_o       (sticky_o[i]),
      .count_o        (count_o[CNT_W*i +: CNT_W]),
      .stab_o         (stab_dbg[i])
    );
  end

  assign irq_o = |sticky_o;

endmodule

// File: tb/tb_edge_monitor.sv
// Directed bench for edge_monitor: a 4-channel instance with FILT_CYC=3,
// CNT_W=8, and a 1-channel instance with CNT_W=2 for counter saturation.
module tb_edge_monitor;

  localparam int N_CH     = 4;
  localparam int FILT_CYC = 3;
  localparam int CNT_W    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic [N_CH-1:0]       a_i, clr_i;
  logic [2*N_CH-1:0]     mode_i;
  logic [N_CH-1:0]       filt_o, rising_edge_o, falling_edge_o, event_o, sticky_o;
  logic [N_CH*CNT_W-1:0] count_o;
  logic                  irq_o;

  // saturation instance
  logic       s_a_i, s_clr_i;
  logic [1:0] s_mode_i;
  logic       s_filt_o, s_rise_o, s_fall_o, s_event_o, s_sticky_o, s_irq_o;
  logic [1:0] s_count_o;

  edge_monitor #(.N_CH(N_CH), .FILT_CYC(FILT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
    .filt_o(filt_o), .rising_edge_o(rising_edge_o), .falling_edge_o(falling_edge_o),
    .event_o(event_o), .sticky_o(sticky_o), .count_o(count_o), .irq_o(irq_o)
  );

  edge_monitor #(.N_CH(1), .FILT_CYC(FILT_CYC), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .a_i(s_a_i), .mode_i(s_mode_i), .clr_i(s_clr_i),
    .filt_o(s_filt_o), .rising_edge_o(s_rise_o), .falling_edge_o(s_fall_o),
    .event_o(s_event_o), .sticky_o(s_sticky_o), .count_o(s_count_o), .irq_o(s_irq_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return count_o[CNT_W*ch +: CNT_W];
  endfunction

  // expected saturation sequence for CNT_W=2
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    reset = 1'b1; a_i = '0; clr_i = '0; mode_i = '0;
    s_a_i = 1'b0; s_clr_i = 1'b0; s_mode_i = 2'b11;
    ticks(2);

    // reset state
    check("rst_filt",   32'(filt_o),   32'h0);
    check("rst_count",  32'(count_o),  32'h0);
    check("rst_sticky", 32'(sticky_o), 32'h0);
    check("rst_irq",    32'(irq_o),    32'h0);
    check("rst_pulses", 32'({rising_edge_o, falling_edge_o, event_o}), 32'h0);
    reset = 1'b0;

    // counter saturation at 2^CNT_W-1, five qualified edges
    for (int k = 0; k < 5; k++) begin
      s_a_i = ~s_a_i;
      ticks(3);
      check("sat_event", 32'(s_event_o), 32'h1);
      tick();
      check($sformatf("sat_count%0d", k), 32'(s_count_o), 32'(sat_exp[k]));
    end

    // ch0 rise-qualified: filter releases on the 3rd edge
    mode_i[1:0] = 2'b01;
    a_i[0] = 1'b1;
    ticks(2);
    check("ch0_filt_edge2", 32'(filt_o[0]), 32'h0);
    tick();
    check("ch0_filt_edge3", 32'(filt_o[0]), 32'h1);
    check("ch0_rise",       32'(rising_edge_o), 32'h1);
    check("ch0_event",      32'(event_o), 32'h1);
    check("ch0_count_pre",  32'(cnt(0)), 32'h0);
    tick();
    check("ch0_rise_one",   32'(rising_edge_o[0]), 32'h0);
    check("ch0_event_one",  32'(event_o[0]), 32'h0);
    check("ch0_count",      32'(cnt(0)), 32'h1);
    check("ch0_sticky",     32'(sticky_o), 32'h1);
    check("ch0_irq",        32'(irq_o), 32'h1);

    // ch3 glitch of 2 samples is rejected; counter restarts afterwards
    mode_i[7:6] = 2'b11;
    a_i[3] = 1'b1;
    ticks(2);
    a_i[3] = 1'b0;
    tick();
    check("glitch_filt",  32'(filt_o[3]), 32'h0);
    check("glitch_pulse", 32'({rising_edge_o[3], event_o[3]}), 32'h0);
    a_i[3] = 1'b1;
    ticks(2);
    check("glitch_restart", 32'(filt_o[3]), 32'h0);
    a_i[3] = 1'b0;
    ticks(2);
    check("glitch_count", 32'(cnt(3)), 32'h0);

    // ch1 fall-qualified: rise pulses without event, fall pulses with event
    mode_i[3:2] = 2'b10;
    a_i[1] = 1'b1;
    ticks(3);
    check("ch1_rise",     32'(rising_edge_o[1]), 32'h1);
    check("ch1_rise_ev",  32'(event_o[1]), 32'h0);
    tick();
    check("ch1_count0",   32'(cnt(1)), 32'h0);
    a_i[1] = 1'b0;
    ticks(3);
    check("ch1_fall",     32'({rising_edge_o[1], falling_edge_o[1]}), 32'h1);
    check("ch1_fall_ev",  32'(event_o[1]), 32'h1);
    tick();
    check("ch1_count1",   32'(cnt(1)), 32'h1);
    check("ch1_sticky",   32'(sticky_o), 32'h3);

    // ch2: clear coincident with an event, plus same-cycle mode change
    mode_i[5:4] = 2'b11;
    a_i[2] = 1'b1;
    ticks(4);
    check("ch2_count_a", 32'(cnt(2)), 32'h1);
    a_i[2] = 1'b0;
    ticks(3);
    check("ch2_fall_ev", 32'(event_o[2]), 32'h1);
    mode_i[5:4] = 2'b00;
    #1;
    check("ch2_mode_off", 32'(event_o[2]), 32'h0);
    mode_i[5:4] = 2'b10;
    #1;
    check("ch2_mode_on",  32'(event_o[2]), 32'h1);
    clr_i[2] = 1'b1;
    tick();
    clr_i[2] = 1'b0;
    check("ch2_clr_ev_sticky", 32'(sticky_o[2]), 32'h1);
    check("ch2_clr_ev_count",  32'(cnt(2)), 32'h1);
    clr_i[2] = 1'b1;
    tick();
    clr_i[2] = 1'b0;
    check("ch2_clr_sticky", 32'(sticky_o[2]), 32'h0);
    check("ch2_clr_count",  32'(cnt(2)), 32'h0);
    check("ch2_other_cnt",  32'(cnt(1)), 32'h1);
    clr_i = 4'hf;
    tick();
    clr_i = '0;
    check("clr_all_irq", 32'(irq_o), 32'h0);

    // reset mid-filter on ch3 (counter at 1), ch0 still held high
    a_i[3] = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_filt",  32'(filt_o), 32'h0);
    check("mid_rst_count", 32'(count_o), 32'h0);
    check("mid_rst_irq",   32'({irq_o, sticky_o}), 32'h0);
    reset = 1'b0;
    ticks(2);
    check("post_rst_edge2", 32'(rising_edge_o), 32'h0);
    tick();
    check("post_rst_edge3", 32'(rising_edge_o), 32'h9);
    check("post_rst_filt",  32'(filt_o), 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
